fifo_burst_reader: RTL and testbench

//  Read-side consumer for the dual-clock FIFO: drains its read port (nempty/re/data_out) in the read clock domain.
//  Re-times the data into a valid/ready stream through a 2-entry skid buffer and frames it into fixed bursts (out_last).
//  On flush, completes a partial burst with pad words, so downstream DDR write sequencers only ever see whole bursts.

---
 rtl/fifo_burst_reader_pkg.sv | 12 +
 rtl/fifo_burst_reader_skid_buf2.sv | 57 +++++
 rtl/fifo_burst_reader.sv | 122 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types for the FIFO burst reader: FSM state encoding and buffer occupancy.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_burst_reader_skid_buf2.sv
// Two-entry valid/ready register buffer; entry 0 drives the output directly.
module skid_buf2
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output occ_t             occ
);

    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    occ_t             occ_q, occ_d;
    occ_t             occ_after_pop;

    // The caller only pushes when there is room after this cycle's pop,
    // so the new word lands in the first slot left free by the shift.
    always_comb begin
        e0_d          = e0_q;
        e1_d          = e1_q;
        occ_after_pop = occ_q - occ_t'(pop);
        occ_d         = occ_after_pop + occ_t'(push);
        if (pop) begin
            e0_d = e1_q;
        end
        if (push) begin
            if (occ_after_pop == 2'd0) begin
                e0_d = push_data;
            end else begin
                e1_d = push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = e0_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains the dual-clock FIFO read port into a valid/ready stream framed as
// fixed-length bursts, padding a partial burst to full length on flush.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    BURST_LOG  = 3,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_nempty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_re,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_pad,
    output logic                  flush_done,
    output logic [CNT_WIDTH-1:0]  out_bursts
);

    localparam int                   BUF_W    = DATA_WIDTH + 2;
    localparam logic [BURST_LOG-1:0] IDX_LAST = '1;

    state_t                 state_q, state_d;
    logic [BURST_LOG-1:0]   idx_q, idx_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   flush_done_q, flush_done_d;
    logic [CNT_WIDTH-1:0]   bursts_q, bursts_d;

    logic                   buf_valid;
    logic [BUF_W-1:0]       buf_data;
    occ_t                   occ;
    logic                   pop, room, data_push, pad_push, push, push_last, pend_now;
    logic [BUF_W-1:0]       push_word;

    // Reset gates the read strobe so the FIFO is never popped while held in reset.
    always_comb begin
        pop       = buf_valid & out_ready;
        room      = ((occ - occ_t'(pop)) != 2'd2);
        data_push = rst_n & fifo_nempty & en & (state_q != ST_PAD) & room;
        pad_push  = (state_q == ST_PAD) & room;
        push      = data_push | pad_push;
        push_last = (idx_q == IDX_LAST);
        push_word = {push_last, pad_push, data_push ? fifo_data : PAD_VALUE};
        idx_d     = idx_q + BURST_LOG'(push);
        bursts_d  = bursts_q + CNT_WIDTH'(pop & buf_data[BUF_W-1]);
    end

    skid_buf2 #(
        .WIDTH(BUF_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_word),
        .pop      (pop),
        .out_valid(buf_valid),
        .out_data (buf_data),
        .occ      (occ)
    );

    // Padding starts only once the FIFO is seen empty, so in-flight data wins.
    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        flush_done_d = 1'b0;
        pend_now     = flush_pend_q | flush;
        case (state_q)
            ST_IDLE: begin
                if (data_push) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (data_push && push_last) begin
                    state_d = ST_IDLE;
                end else if (flush_pend_q && !fifo_nempty && !data_push) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                if (pad_push && push_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (pend_now && (state_d == ST_IDLE)) begin
            flush_pend_d = 1'b0;
            flush_done_d = 1'b1;
        end else begin
            flush_pend_d = pend_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
            bursts_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= flush_done_d;
            bursts_q     <= bursts_d;
        end
    end

    assign fifo_re    = data_push;
    assign out_valid  = buf_valid;
    assign out_data   = buf_data[DATA_WIDTH-1:0];
    assign out_pad    = buf_data[DATA_WIDTH];
    assign out_last   = buf_data[DATA_WIDTH+1];
    assign flush_done = flush_done_q;
    assign out_bursts = bursts_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based model of the framed output stream
// plus directed scenarios with hand-computed expectations.
module tb_fifo_burst_reader;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        pad;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n, en, flush, out_ready;
    logic        fifo_nempty, fifo_re;
    logic [15:0] fifo_data;
    logic        out_valid, out_last, out_pad, flush_done;
    logic [15:0] out_data, out_bursts;

    logic        w_en;
    logic        w_fifo_re, w_out_valid, w_out_last, w_out_pad, w_flush_done;
    logic [15:0] w_out_data;
    logic [3:0]  w_out_bursts;

    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    int          n_checks = 0;
    int          n_fails  = 0;

    word_t       exp_q[$];
    word_t       held;
    int          pos = 0;
    logic [15:0] model_bursts = '0;
    logic [3:0]  w_bursts = '0;
    logic [3:0]  w_prev = '0;
    logic        wrap_seen = 1'b0;
    logic        stall_prev = 1'b0;
    int          pad_pops = 0;
    int          flush_reqs = 0;
    int          done_seen = 0;

    always #5 clk = ~clk;

    assign fifo_nempty = (wr_ptr != rd_ptr);
    assign fifo_data   = mem[rd_ptr[7:0]];

    // Bench FIFO: its own synchronous reset, popped by the DUT read strobe.
    always @(posedge clk) begin
        if (!rst_n) rd_ptr <= wr_ptr;
        else if (fifo_re) rd_ptr <= rd_ptr + 1;
    end

    fifo_burst_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .fifo_nempty(fifo_nempty),
        .fifo_data  (fifo_data),
        .fifo_re    (fifo_re),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_pad    (out_pad),
        .flush_done (flush_done),
        .out_bursts (out_bursts)
    );

    // Short bursts and a narrow counter make the wrap reachable in a few dozen cycles.
    fifo_burst_reader #(
        .DATA_WIDTH(16),
        .BURST_LOG (1),
        .PAD_VALUE (16'h0),
        .CNT_WIDTH (4)
    ) dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (w_en),
        .flush      (1'b0),
        .fifo_nempty(1'b1),
        .fifo_data  (16'h00A5),
        .fifo_re    (w_fifo_re),
        .out_valid  (w_out_valid),
        .out_ready  (1'b1),
        .out_data   (w_out_data),
        .out_last   (w_out_last),
        .out_pad    (w_out_pad),
        .flush_done (w_flush_done),
        .out_bursts (w_out_bursts)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [15:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr++;
    endtask

    task automatic wait_flush_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (flush_done) begin
                seen = 1'b1;
                break;
            end
        end
        check_output(name, seen, 1'b1);
    endtask

    initial begin
        int cur_streak;
        int max_streak;
        int pad_base;
        logic first_re;
        logic pat [4];

        rst_n = 1'b0; en = 1'b0; flush = 1'b0; out_ready = 1'b1; w_en = 1'b0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        cur_streak = 0; max_streak = 0; first_re = 1'b0;

        // Model and per-cycle compare process, sampled on the falling edge.
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    exp_q.delete();
                    pos = 0; model_bursts = '0; w_bursts = '0; w_prev = '0; stall_prev = 1'b0;
                    check_output("reset_out_valid", out_valid, 1'b0);
                    check_output("reset_fifo_re", fifo_re, 1'b0);
                    check_output("reset_out_bursts", out_bursts, 16'h0);
                    check_output("reset_flush_done", flush_done, 1'b0);
                end else begin
                    if (stall_prev) begin
                        check_output("hold_data", out_data, held.data);
                        check_output("hold_last", out_last, held.last);
                        check_output("hold_pad", out_pad, held.pad);
                    end
                    check_output("out_bursts", out_bursts, model_bursts);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fails++;
                            $display("[TB] FAIL unexpected_word: got data %0h, model has nothing queued", out_data);
                        end else begin
                            word_t w;
                            w = exp_q.pop_front();
                            check_output("word_data", out_data, w.data);
                            check_output("word_last", out_last, w.last);
                            check_output("word_pad", out_pad, w.pad);
                            if (w.pad) pad_pops++;
                            if (w.last) model_bursts = model_bursts + 16'd1;
                        end
                    end
                    stall_prev = out_valid && !out_ready;
                    held.data = out_data; held.last = out_last; held.pad = out_pad;
                    if (fifo_re) begin
                        exp_q.push_back('{data: fifo_data, last: (pos == 7), pad: 1'b0});
                        pos = (pos + 1) % 8;
                    end
                    if (flush) begin
                        flush_reqs++;
                        if (pos != 0) begin
                            for (int k = pos; k < 8; k++) exp_q.push_back('{data: 16'h0, last: (k == 7), pad: 1'b1});
                            pos = 0;
                        end
                    end
                    if (flush_done) done_seen++;
                    check_output("w_out_bursts", w_out_bursts, w_bursts);
                    check_output("w_fifo_re", w_fifo_re, w_en);
                    check_output("w_flush_done", w_flush_done, 1'b0);
                    if (w_out_valid) begin
                        check_output("w_out_data", w_out_data, 16'h00A5);
                        check_output("w_out_pad", w_out_pad, 1'b0);
                        if (w_out_last) w_bursts = w_bursts + 4'd1;
                    end
                    if (w_prev == 4'hF && w_out_bursts == 4'h0) wrap_seen = 1'b1;
                    w_prev = w_out_bursts;
                end
            end
        join_none

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 16 words stream through as two bursts, read back-to-back.
        for (int i = 0; i < 16; i++) apply_stimulus(16'(i));
        en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 0) first_re = fifo_re;
            if (i == 1) begin
                check_output("t1_latency_valid", out_valid, 1'b1);
                check_output("t1_latency_data", out_data, 16'h0);
            end
            if (fifo_re) begin
                cur_streak++;
                if (cur_streak > max_streak) max_streak = cur_streak;
            end else begin
                cur_streak = 0;
            end
        end
        tick();
        check_output("t1_first_re", first_re, 1'b1);
        check_output("t1_re_streak", max_streak, 16);
        check_output("t1_bursts", out_bursts, 16'd2);

        // Three words then flush: five pads close the burst.
        apply_stimulus(16'h0A0A); apply_stimulus(16'h0B0B); apply_stimulus(16'h0C0C);
        repeat (5) tick();
        pad_base = pad_pops;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_flush_done("t2_flush_done_seen");
        check_output("t2_done_with_last_pad", {out_valid, out_last, out_pad}, 3'b111);
        tick();
        check_output("t2_pad_count", pad_pops - pad_base, 5);
        check_output("t2_bursts", out_bursts, 16'd3);

        // Flush while idle completes next cycle with no pads.
        pad_base = pad_pops;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("t4_idle_done", flush_done, 1'b1);
        tick();
        check_output("t4_done_one_cycle", flush_done, 1'b0);

        // Flush coinciding with the eighth word: no pads.
        for (int i = 0; i < 7; i++) apply_stimulus(16'h4000 + 16'(i));
        repeat (10) tick();
        apply_stimulus(16'h4007);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("t4_last_flush_done", flush_done, 1'b1);
        repeat (3) tick();
        check_output("t4_no_pads", pad_pops - pad_base, 0);
        check_output("t4_bursts", out_bursts, 16'd4);

        // Backpressure pattern 1,0,0,1: buffer fills and reads stop.
        for (int i = 0; i < 11; i++) apply_stimulus(16'h3000 + 16'(i));
        for (int r = 0; r < 16; r++) begin
            out_ready = pat[r % 4];
            @(negedge clk);
            if ((r % 4) == 2) check_output("t3_full_no_read", fifo_re, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        repeat (8) tick();

        // Reset with two words buffered at burst index 5.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus(16'h5000 + 16'(i));
        repeat (4) tick();
        check_output("t5_pre_valid", out_valid, 1'b1);
        check_output("t5_pre_no_read", fifo_re, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t5_async_valid", out_valid, 1'b0);
        check_output("t5_async_re", fifo_re, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        check_output("t5_bursts_cleared", out_bursts, 16'd0);
        for (int i = 0; i < 8; i++) apply_stimulus(16'h6000 + 16'(i));
        repeat (12) tick();
        check_output("t5_new_burst", out_bursts, 16'd1);

        // en low: no reads while the buffer drains.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) apply_stimulus(16'h7000 + 16'(i));
        repeat (3) tick();
        en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("t6_no_read", fifo_re, 1'b0);
        end
        tick();
        check_output("t6_drained", out_valid, 1'b0);
        en = 1'b1;
        repeat (6) tick();
        pad_base = pad_pops;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_flush_done("t6_flush_done_seen");
        tick();
        check_output("t6_pad_count", pad_pops - pad_base, 2);
        check_output("t6_bursts", out_bursts, 16'd2);

        // Burst counter wrap on the narrow-counter instance.
        w_en = 1'b1;
        repeat (40) tick();
        w_en = 1'b0;
        tick();
        check_output("wrap_seen", wrap_seen, 1'b1);

        check_output("model_drained", exp_q.size(), 0);
        check_output("flush_done_count", done_seen, flush_reqs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
